// File: rtl/buffer_double_pkg.sv
// Shared types and helpers for the ping-pong stream buffer.
package buffer_double_pkg;

    typedef logic bank_t;

    // Counters must hold the value DEPTH itself (a full bank length).
    function automatic int cntw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/buffer_double_bank.sv
// One bank of the ping-pong buffer: DEPTH x OWID register file,
// single write port, combinational read port, async active-high clear.
module buffer_double_bank #(
    parameter int DEPTH = 4,
    parameter int OWID  = 10,
    parameter int AW    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [OWID-1:0] wr_data,
    input  logic [AW-1:0]   rd_addr,
    output logic [OWID-1:0] rd_data
);

    logic [OWID-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/buffer_double_stream.sv
// Ping-pong double buffer with valid/ready on both sides; banks swap on full/empty.
// Optional BUFFER_DOUBLE_FLUSH_EN adds iFlush to close a partially filled bank early.
module buffer_double_stream
    import buffer_double_pkg::*;
#(
    parameter int IWID  = 10,
    parameter int OWID  = IWID,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iValid,
    output logic            iReady,
    input  logic [IWID-1:0] iData,
    output logic            oValid,
    input  logic            oReady,
    output logic [OWID-1:0] oData,
    output logic            oLast,
`ifdef BUFFER_DOUBLE_FLUSH_EN
    input  logic            iFlush,
`endif
    output logic            oWBank
);

    localparam int CW = cntw(DEPTH);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST_W = CW'(DEPTH - 1);

    bank_t           w_bank;
    bank_t           r_bank;
    logic [CW-1:0]   w_cnt;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      full;
    logic [1:0]      full_nxt;
    logic [CW-1:0]   len_rd;
    logic            wr_fire;
    logic            rd_fire;
    logic            w_close;
    logic            r_done;
    logic [OWID-1:0] wr_word;
    logic [OWID-1:0] rd_data [2];

    assign iReady  = ~full[w_bank];
    assign oValid  = full[r_bank];
    assign oWBank  = w_bank;
    assign wr_fire = iValid && iReady;
    assign rd_fire = oValid && oReady;
    assign wr_word = OWID'(iData);

`ifdef BUFFER_DOUBLE_FLUSH_EN
    logic [CW-1:0] len [2];
    logic [CW-1:0] w_cnt_inc;

    // Word count of the fill bank including this cycle's write; becomes the bank length on close.
    assign w_cnt_inc = w_cnt + CW'(wr_fire);
    assign w_close   = (wr_fire && (w_cnt == LAST_W)) ||
                       (iFlush && !full[w_bank] && (w_cnt_inc != '0));
    assign len_rd    = len[r_bank];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len[0] <= CW'(DEPTH);
            len[1] <= CW'(DEPTH);
        end else if (w_close) begin
            len[w_bank] <= w_cnt_inc;
        end
    end
`else
    assign w_close = wr_fire && (w_cnt == LAST_W);
    assign len_rd  = CW'(DEPTH);
`endif

    assign r_done = rd_fire && (r_cnt == len_rd - CW'(1));
    assign oLast  = oValid && (r_cnt == len_rd - CW'(1));

    // Read empties rBank and write fills wBank; when both fire they are always different banks.
    always_comb begin
        full_nxt = full;
        if (r_done) full_nxt[r_bank] = 1'b0;
        if (w_close) full_nxt[w_bank] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_bank <= 1'b0;
            r_bank <= 1'b0;
            w_cnt  <= '0;
            r_cnt  <= '0;
            full   <= '0;
        end else begin
            full <= full_nxt;
            if (w_close) begin
                w_cnt  <= '0;
                w_bank <= ~w_bank;
            end else if (wr_fire) begin
                w_cnt <= w_cnt + CW'(1);
            end
            if (r_done) begin
                r_cnt  <= '0;
                r_bank <= ~r_bank;
            end else if (rd_fire) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        buffer_double_bank #(
            .DEPTH (DEPTH),
            .OWID  (OWID),
            .AW    (AW)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_fire && (w_bank == bank_t'(b))),
            .wr_addr (w_cnt[AW-1:0]),
            .wr_data (wr_word),
            .rd_addr (r_cnt[AW-1:0]),
            .rd_data (rd_data[b])
        );
    end

    assign oData = rd_data[r_bank];

endmodule

// File: tb/tb_buffer_double_stream.sv
// Directed and randomized checks of buffer_double_stream against a queue-based model.
module tb_buffer_double_stream;

    localparam int IWID  = 10;
    localparam int OWID  = 10;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            iValid = 1'b0;
    logic            iReady;
    logic [IWID-1:0] iData = '0;
    logic            oValid;
    logic            oReady = 1'b0;
    logic [OWID-1:0] oData;
    logic            oLast;
    logic            oWBank;
`ifdef BUFFER_DOUBLE_FLUSH_EN
    logic            iFlush = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Model: closed banks as one FIFO of words plus a FIFO of bank lengths.
    int q_data[$];
    int q_len[$];
    int fill[$];
    int rd_pos = 0;
    int closes = 0;

    buffer_double_stream #(.IWID(IWID), .OWID(OWID), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .iValid (iValid),
        .iReady (iReady),
        .iData  (iData),
        .oValid (oValid),
        .oReady (oReady),
        .oData  (oData),
        .oLast  (oLast),
`ifdef BUFFER_DOUBLE_FLUSH_EN
        .iFlush (iFlush),
`endif
        .oWBank (oWBank)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_data.delete();
        q_len.delete();
        fill.delete();
        rd_pos = 0;
        closes = 0;
    endtask

    // Drive one cycle of inputs, check state-derived outputs, advance the model.
    task automatic step(input logic iv, input int d, input logic ordy, input logic fl);
        bit rdy;
        bit vld;
        @(negedge clk);
        iValid = iv;
        iData  = IWID'(d);
        oReady = ordy;
`ifdef BUFFER_DOUBLE_FLUSH_EN
        iFlush = fl;
`endif
        #1;
        rdy = (q_len.size() < 2);
        vld = (q_len.size() > 0);
        chk("iReady", 32'(iReady), 32'(rdy));
        chk("oValid", 32'(oValid), 32'(vld));
        chk("oWBank", 32'(oWBank), 32'(closes % 2));
        if (vld) begin
            chk("oData", 32'(oData), 32'(q_data[0]));
            chk("oLast", 32'(oLast), 32'(rd_pos == q_len[0] - 1));
        end else begin
            chk("oLast_idle", 32'(oLast), 32'd0);
        end
        if (vld && ordy) begin
            void'(q_data.pop_front());
            rd_pos++;
            if (rd_pos == q_len[0]) begin
                void'(q_len.pop_front());
                rd_pos = 0;
            end
        end
        if (iv && rdy) fill.push_back(d % (1 << IWID));
`ifdef BUFFER_DOUBLE_FLUSH_EN
        if (fill.size() == DEPTH || (fl && fill.size() > 0 && rdy)) begin
`else
        if (fill.size() == DEPTH) begin
`endif
            foreach (fill[i]) q_data.push_back(fill[i]);
            q_len.push_back(fill.size());
            fill.delete();
            closes++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        iValid = 1'b0;
        oReady = 1'b0;
`ifdef BUFFER_DOUBLE_FLUSH_EN
        iFlush = 1'b0;
`endif
        #2;
        rst = 1'b1;
        #1;
        chk("rst_oValid", 32'(oValid), 32'd0);
        chk("rst_iReady", 32'(iReady), 32'd1);
        chk("rst_oWBank", 32'(oWBank), 32'd0);
        chk("rst_oData", 32'(oData), 32'd0);
        chk("rst_oLast", 32'(oLast), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int exp_next;
        bit seen;
        int reads;

        // Fill one bank: swap after 4th word, first word visible next cycle.
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        chk("t1_oWBank", 32'(oWBank), 32'd1);
        chk("t1_oValid", 32'(oValid), 32'd1);
        chk("t1_oData", 32'(oData), 32'd1);

        // Both banks full: writes stall and data holds.
        do_reset();
        for (int i = 1; i <= 8; i++) step(1'b1, i, 1'b0, 1'b0);
        step(1'b1, 9, 1'b0, 1'b0);
        chk("t2_iReady", 32'(iReady), 32'd0);
        step(1'b1, 10, 1'b0, 1'b0);
        chk("t2_oData_hold", 32'(oData), 32'd1);
        for (int i = 0; i < 10; i++) step(1'b0, 0, 1'b1, 1'b0);

        // Continuous stream 1..16: in order, oLast every 4th, one word per cycle.
        do_reset();
        exp_next = 1;
        seen = 0;
        reads = 0;
        for (int c = 0; c < 24; c++) begin
            step(c < 16, c + 1, 1'b1, 1'b0);
            if (seen && reads < 16) chk("t3_thru", 32'(oValid), 32'd1);
            if (oValid) begin
                seen = 1;
                chk("t3_order", 32'(oData), 32'(exp_next));
                chk("t3_last", 32'(oLast), 32'(exp_next % 4 == 0));
                exp_next++;
                reads++;
            end
        end
        chk("t3_count", 32'(reads), 32'd16);

        // Reset mid-transfer, then only new words come out.
        do_reset();
        step(1'b1, 100, 1'b0, 1'b0);
        step(1'b1, 101, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 200 + i, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        chk("t5_first", 32'(oData), 32'd200);
        for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b1, 1'b0);

`ifdef BUFFER_DOUBLE_FLUSH_EN
        // Flush a 2-word bank.
        do_reset();
        step(1'b1, 7, 1'b0, 1'b0);
        step(1'b1, 9, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0);
        chk("t6_first", 32'(oData), 32'd7);
        step(1'b0, 0, 1'b1, 1'b0);
        chk("t6_last", 32'(oLast), 32'd1);
        chk("t6_second", 32'(oData), 32'd9);
        step(1'b0, 0, 1'b0, 1'b0);
        chk("t6_drained", 32'(oValid), 32'd0);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 1023)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
